change_hopper_ctrl: RTL and testbench

CHANGE_HOPPER_CTRL -- requirements
Module: change_hopper_ctrl

---
 rtl/vend_pkg.sv | 23 ++
 rtl/payout_fifo.sv | 63 ++++++
 rtl/change_hopper_ctrl.sv | 167 ++++++++++++++++
 tb/tb_change_hopper_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// vend_pkg : shared types and default constants for the vending change path
// Rev 1.0
// ============================================================================
package vend_pkg;

   localparam int C_FIFO_DEPTH     = 4;
   localparam int C_TIMEOUT_CYCLES = 16;
   localparam int C_GAP_CYCLES     = 2;
   localparam int C_INV_W          = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KICK  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_GAP   = 3'd3,
      ST_JAM   = 3'd4,
      ST_EMPTY = 3'd5
   } hopper_state_t;

endpackage
`default_nettype wire

// File: rtl/payout_fifo.sv
`default_nettype none
// ============================================================================
// payout_fifo : synchronous request queue of per-request coin counts
// Rev 1.0
// ============================================================================
module payout_fifo
   import vend_pkg::*;
#(
   parameter int DEPTH = C_FIFO_DEPTH,
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr_en;
   logic             w_rd_en;

   // Pointers wrap explicitly so DEPTH need not be a power of two
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (r_count == CW'(DEPTH));
   assign empty   = (r_count == '0);
   assign w_wr_en = push && !full;
   assign w_rd_en = pop && !empty;
   assign head    = r_mem[r_rd_ptr];

   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_wr_en && !w_rd_en)      r_count <= r_count + CW'(1);
         else if (!w_wr_en && w_rd_en) r_count <= r_count - CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/change_hopper_ctrl.sv
`default_nettype none
// ============================================================================
// change_hopper_ctrl : queues 100-yen payouts and drives the coin hopper
// Rev 1.0
// ============================================================================
module change_hopper_ctrl
   import vend_pkg::*;
#(
   parameter int FIFO_DEPTH     = C_FIFO_DEPTH,
   parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES,
   parameter int GAP_CYCLES     = C_GAP_CYCLES,
   parameter int INV_W          = C_INV_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             payout_req,
   input  logic [3:0]       payout_count,
   input  logic             hopper_coin_sensed,
   input  logic             refill,
   input  logic [INV_W-1:0] refill_count,
   input  logic             clear_jam,
   output logic             hopper_kick,
   output logic             paying,
   output logic             jam,
   output logic             empty_alarm,
   output logic             req_overflow,
   output logic [INV_W-1:0] coins_owed,
   output logic [INV_W-1:0] coins_left
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [INV_W-1:0] C_INV_MAX = '1;

   hopper_state_t    r_state, w_state_next;
   logic [3:0]       r_remaining, w_remaining_next;
   logic [TW-1:0]    r_timer, w_timer_next;
   logic [GW-1:0]    r_gap, w_gap_next;
   logic [INV_W-1:0] r_coins_left, r_coins_owed;
   logic [INV_W-1:0] w_left_next, w_owed_next;
   logic [INV_W:0]   w_left_acc, w_owed_acc;
   logic             r_hopper_kick, r_paying, r_jam, r_empty_alarm, r_req_overflow;
   logic             w_kick_next, w_pop, w_push, w_drop, w_sense_ok;
   logic [3:0]       w_fifo_head;
   logic             w_fifo_full, w_fifo_empty;

   assign w_push = payout_req && (payout_count != 4'd0) && !w_fifo_full;
   assign w_drop = payout_req && (payout_count != 4'd0) && w_fifo_full;

   payout_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (4)
   ) u_payout_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push),
      .push_data (payout_count),
      .pop       (w_pop),
      .head      (w_fifo_head),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty)
   );

   always_comb begin
      w_state_next     = r_state;
      w_remaining_next = r_remaining;
      w_timer_next     = r_timer;
      w_gap_next       = r_gap;
      w_kick_next      = 1'b0;
      w_pop            = 1'b0;
      w_sense_ok       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop            = 1'b1;
               w_remaining_next = w_fifo_head;
               w_state_next     = ST_KICK;
            end
         end
         ST_KICK: begin
            if (r_coins_left != '0) begin
               w_kick_next  = 1'b1;
               w_timer_next = '0;
               w_state_next = ST_WAIT;
            end else begin
               w_state_next = ST_EMPTY;
            end
         end
         ST_WAIT: begin
            // A sense on the final timer cycle still counts as a good coin
            if (hopper_coin_sensed) begin
               w_sense_ok       = 1'b1;
               w_remaining_next = r_remaining - 4'd1;
               w_gap_next       = '0;
               w_state_next     = ST_GAP;
            end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
               w_state_next = ST_JAM;
            end else begin
               w_timer_next = r_timer + TW'(1);
            end
         end
         ST_GAP: begin
            if (r_gap == GW'(GAP_CYCLES - 1)) begin
               w_state_next = (r_remaining != 4'd0) ? ST_KICK : ST_IDLE;
            end else begin
               w_gap_next = r_gap + GW'(1);
            end
         end
         ST_JAM: begin
            if (clear_jam) w_state_next = ST_KICK;
         end
         ST_EMPTY: begin
            if (refill) w_state_next = ST_KICK;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Inventory and owed totals: add first, then take the sensed coin, then clamp
   always_comb begin
      w_left_acc = {1'b0, r_coins_left} + (refill ? {1'b0, refill_count} : '0);
      if (w_sense_ok && (w_left_acc != '0)) w_left_acc = w_left_acc - (INV_W+1)'(1);
      w_left_next = w_left_acc[INV_W] ? C_INV_MAX : w_left_acc[INV_W-1:0];

      w_owed_acc = {1'b0, r_coins_owed} + (w_push ? (INV_W+1)'(payout_count) : '0);
      if (w_sense_ok && (w_owed_acc != '0)) w_owed_acc = w_owed_acc - (INV_W+1)'(1);
      w_owed_next = w_owed_acc[INV_W] ? C_INV_MAX : w_owed_acc[INV_W-1:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_remaining    <= '0;
         r_timer        <= '0;
         r_gap          <= '0;
         r_coins_left   <= '0;
         r_coins_owed   <= '0;
         r_hopper_kick  <= 1'b0;
         r_paying       <= 1'b0;
         r_jam          <= 1'b0;
         r_empty_alarm  <= 1'b0;
         r_req_overflow <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_remaining    <= w_remaining_next;
         r_timer        <= w_timer_next;
         r_gap          <= w_gap_next;
         r_coins_left   <= w_left_next;
         r_coins_owed   <= w_owed_next;
         r_hopper_kick  <= w_kick_next;
         r_paying       <= (w_state_next != ST_IDLE) || w_push || !w_fifo_empty;
         r_jam          <= (w_state_next == ST_JAM);
         r_empty_alarm  <= (w_state_next == ST_EMPTY);
         r_req_overflow <= w_drop;
      end
   end

   assign hopper_kick  = r_hopper_kick;
   assign paying       = r_paying;
   assign jam          = r_jam;
   assign empty_alarm  = r_empty_alarm;
   assign req_overflow = r_req_overflow;
   assign coins_owed   = r_coins_owed;
   assign coins_left   = r_coins_left;

endmodule
`default_nettype wire

// File: tb/tb_change_hopper_ctrl.sv
`default_nettype none
// ============================================================================
// tb_change_hopper_ctrl : scenario tasks plus randomized payouts vs. a coin model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_change_hopper_ctrl;

   localparam int FIFO_DEPTH     = 4;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int GAP_CYCLES     = 2;
   localparam int INV_W          = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             payout_req = 1'b0;
   logic [3:0]       payout_count = '0;
   logic             hopper_coin_sensed = 1'b0;
   logic             refill = 1'b0;
   logic [INV_W-1:0] refill_count = '0;
   logic             clear_jam = 1'b0;
   logic             hopper_kick, paying, jam, empty_alarm, req_overflow;
   logic [INV_W-1:0] coins_owed, coins_left;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int kick_times[$];
   int ovf_cnt = 0;
   int hop_delay = 2;
   bit hop_auto = 1'b0;
   int sense_cd = 0;
   int man_req = 0;
   int man_ack = 0;

   change_hopper_ctrl #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .GAP_CYCLES     (GAP_CYCLES),
      .INV_W          (INV_W)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .payout_req         (payout_req),
      .payout_count       (payout_count),
      .hopper_coin_sensed (hopper_coin_sensed),
      .refill             (refill),
      .refill_count       (refill_count),
      .clear_jam          (clear_jam),
      .hopper_kick        (hopper_kick),
      .paying             (paying),
      .jam                (jam),
      .empty_alarm        (empty_alarm),
      .req_overflow       (req_overflow),
      .coins_owed         (coins_owed),
      .coins_left         (coins_left)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Hopper model: answers each kick with a sense hop_delay cycles later
   always @(posedge clock) begin
      #2;
      hopper_coin_sensed = 1'b0;
      if (sense_cd > 0) begin
         sense_cd--;
         if (sense_cd == 0) hopper_coin_sensed = 1'b1;
      end
      if (hopper_kick === 1'b1) begin
         kick_times.push_back(cyc);
         if (hop_auto) begin
            if (hop_delay == 0) hopper_coin_sensed = 1'b1;
            else sense_cd = hop_delay;
         end
      end
      if (man_req != man_ack) begin
         hopper_coin_sensed = 1'b1;
         man_ack = man_req;
      end
      if (req_overflow === 1'b1) ovf_cnt++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_refill(input int n);
      refill = 1'b1;
      refill_count = INV_W'(n);
      tick();
      refill = 1'b0;
      refill_count = '0;
   endtask

   task automatic do_request(input int n);
      payout_req = 1'b1;
      payout_count = 4'(n);
      tick();
      payout_req = 1'b0;
      payout_count = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input int budget, output bit idle);
      int n = 0;
      while (paying === 1'b1 && n < budget) begin
         tick();
         n++;
      end
      idle = (paying === 1'b0);
   endtask

   task automatic wait_kick(output bit seen);
      int n = 0;
      while (hopper_kick !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      seen = (hopper_kick === 1'b1);
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++; if (hopper_kick !== 1'b0) begin failures++; $display("FAIL reset_kick: got %b want 0", hopper_kick); end
      checks++; if (paying !== 1'b0) begin failures++; $display("FAIL reset_paying: got %b want 0", paying); end
      checks++; if (jam !== 1'b0 || empty_alarm !== 1'b0) begin failures++; $display("FAIL reset_alarms: jam=%b empty=%b want 0 0", jam, empty_alarm); end
      checks++; if (req_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", req_overflow); end
      checks++; if (coins_owed !== '0 || coins_left !== '0) begin failures++; $display("FAIL reset_counts: owed=%0d left=%0d want 0 0", coins_owed, coins_left); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int s;
      bit idle;
      hop_auto = 1'b1;
      hop_delay = 2;
      do_refill(10);
      checks++; if (coins_left !== INV_W'(10)) begin failures++; $display("FAIL basic_refill: left=%0d want 10", coins_left); end
      s = kick_times.size();
      do_request(3);
      checks++; if (coins_owed !== INV_W'(3)) begin failures++; $display("FAIL basic_owed_push: owed=%0d want 3", coins_owed); end
      wait_idle(200, idle);
      checks++; if (!idle) begin failures++; $display("FAIL basic_idle: paying still high, want 0"); end
      checks++; if (kick_times.size() - s != 3) begin failures++; $display("FAIL basic_kicks: got %0d want 3", kick_times.size() - s); end
      checks++; if (coins_left !== INV_W'(7) || coins_owed !== '0) begin failures++; $display("FAIL basic_counts: left=%0d owed=%0d want 7 0", coins_left, coins_owed); end
      // One KICK cycle, WAIT lasts delay+1 cycles, then the GAP
      for (int i = s + 1; i < kick_times.size(); i++) begin
         checks++;
         if (kick_times[i] - kick_times[i-1] != hop_delay + 2 + GAP_CYCLES) begin
            failures++;
            $display("FAIL basic_spacing: got %0d want %0d", kick_times[i] - kick_times[i-1], hop_delay + 2 + GAP_CYCLES);
         end
      end
   endtask

   task automatic test_jam();
      int left0, s, c_jam, n;
      bit idle;
      hop_auto = 1'b0;
      left0 = int'(coins_left);
      s = kick_times.size();
      do_request(2);
      n = 0;
      while (jam !== 1'b1 && n < 60) begin tick(); n++; end
      c_jam = cyc;
      checks++; if (jam !== 1'b1) begin failures++; $display("FAIL jam_set: jam=%b want 1", jam); end
      checks++; if (kick_times.size() - s != 1) begin failures++; $display("FAIL jam_kicks: got %0d want 1", kick_times.size() - s); end
      if (kick_times.size() > s) begin
         checks++;
         if (c_jam - kick_times[s] != TIMEOUT_CYCLES) begin failures++; $display("FAIL jam_timeout: got %0d want %0d", c_jam - kick_times[s], TIMEOUT_CYCLES); end
      end
      checks++; if (coins_left !== INV_W'(left0)) begin failures++; $display("FAIL jam_left_hold: left=%0d want %0d", coins_left, left0); end
      s = kick_times.size();
      hop_auto = 1'b1;
      hop_delay = 1;
      clear_jam = 1'b1;
      tick();
      clear_jam = 1'b0;
      wait_idle(100, idle);
      checks++; if (!idle) begin failures++; $display("FAIL jam_drain: paying still high, want 0"); end
      checks++; if (kick_times.size() - s != 2) begin failures++; $display("FAIL jam_retry_kicks: got %0d want 2", kick_times.size() - s); end
      checks++; if (coins_left !== INV_W'(left0 - 2) || coins_owed !== '0 || jam !== 1'b0) begin
         failures++; $display("FAIL jam_final: left=%0d owed=%0d jam=%b want %0d 0 0", coins_left, coins_owed, jam, left0 - 2);
      end
   endtask

   task automatic test_timeout_edge();
      int left0;
      bit seen, idle;
      hop_auto = 1'b0;
      left0 = int'(coins_left);
      do_request(1);
      wait_kick(seen);
      checks++; if (!seen) begin failures++; $display("FAIL edge_kick: no kick, want 1"); end
      repeat (TIMEOUT_CYCLES - 1) tick();
      man_req++;
      tick();
      checks++; if (jam !== 1'b0 || coins_left !== INV_W'(left0 - 1)) begin
         failures++; $display("FAIL edge_sense_wins: jam=%b left=%0d want 0 %0d", jam, coins_left, left0 - 1);
      end
      wait_idle(20, idle);
      checks++; if (!idle || coins_owed !== '0) begin failures++; $display("FAIL edge_idle: paying=%b owed=%0d want 0 0", paying, coins_owed); end
   endtask

   task automatic test_empty();
      int s, n;
      bit idle;
      do_reset();
      hop_auto = 1'b1;
      hop_delay = 1;
      do_refill(1);
      s = kick_times.size();
      do_request(3);
      n = 0;
      while (empty_alarm !== 1'b1 && n < 60) begin tick(); n++; end
      checks++; if (empty_alarm !== 1'b1) begin failures++; $display("FAIL empty_alarm: got %b want 1", empty_alarm); end
      checks++; if (kick_times.size() - s != 1 || coins_left !== '0 || coins_owed !== INV_W'(2)) begin
         failures++; $display("FAIL empty_state: kicks=%0d left=%0d owed=%0d want 1 0 2", kick_times.size() - s, coins_left, coins_owed);
      end
      do_refill(5);
      wait_idle(100, idle);
      checks++; if (!idle) begin failures++; $display("FAIL empty_drain: paying still high, want 0"); end
      checks++; if (kick_times.size() - s != 3 || coins_left !== INV_W'(3) || empty_alarm !== 1'b0) begin
         failures++; $display("FAIL empty_final: kicks=%0d left=%0d empty=%b want 3 3 0", kick_times.size() - s, coins_left, empty_alarm);
      end
   endtask

   task automatic test_overflow();
      int s, ovf0, n;
      bit idle;
      do_reset();
      hop_auto = 1'b1;
      hop_delay = 1;
      s = kick_times.size();
      // First request becomes the active payout and parks in EMPTY
      do_request(1);
      n = 0;
      while (empty_alarm !== 1'b1 && n < 20) begin tick(); n++; end
      ovf0 = ovf_cnt;
      for (int i = 0; i < 4; i++) do_request(1);
      checks++; if (req_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", req_overflow); end
      do_request(1);
      checks++; if (req_overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse: got %b want 1", req_overflow); end
      do_request(0);
      checks++; if (req_overflow !== 1'b0) begin failures++; $display("FAIL ovf_zero_count: got %b want 0", req_overflow); end
      tick();
      checks++; if (ovf_cnt - ovf0 != 1) begin failures++; $display("FAIL ovf_count: got %0d want 1", ovf_cnt - ovf0); end
      checks++; if (coins_owed !== INV_W'(5) || empty_alarm !== 1'b1 || paying !== 1'b1) begin
         failures++; $display("FAIL ovf_state: owed=%0d empty=%b paying=%b want 5 1 1", coins_owed, empty_alarm, paying);
      end
      do_refill(20);
      wait_idle(200, idle);
      checks++; if (!idle || kick_times.size() - s != 5 || coins_left !== INV_W'(15)) begin
         failures++; $display("FAIL ovf_drain: idle=%b kicks=%0d left=%0d want 1 5 15", idle, kick_times.size() - s, coins_left);
      end
   endtask

   task automatic test_simultaneous();
      bit seen, idle;
      do_reset();
      hop_auto = 1'b0;
      do_refill(2);
      do_request(1);
      wait_kick(seen);
      refill = 1'b1;
      refill_count = INV_W'(4);
      man_req++;
      tick();
      refill = 1'b0;
      refill_count = '0;
      checks++; if (!seen || coins_left !== INV_W'(5) || coins_owed !== '0) begin
         failures++; $display("FAIL simul_refill_sense: kick=%b left=%0d owed=%0d want 1 5 0", seen, coins_left, coins_owed);
      end
      wait_idle(20, idle);
      man_req++;
      tick();
      tick();
      checks++; if (!idle || coins_left !== INV_W'(5)) begin failures++; $display("FAIL stray_sense: idle=%b left=%0d want 1 5", idle, coins_left); end
   endtask

   task automatic test_saturation();
      bit seen, idle;
      do_refill(250);
      do_refill(10);
      checks++; if (coins_left !== INV_W'(255)) begin failures++; $display("FAIL sat_refill: left=%0d want 255", coins_left); end
      hop_auto = 1'b0;
      do_request(1);
      wait_kick(seen);
      refill = 1'b1;
      refill_count = INV_W'(5);
      man_req++;
      tick();
      refill = 1'b0;
      refill_count = '0;
      checks++; if (!seen || coins_left !== INV_W'(255)) begin failures++; $display("FAIL sat_sense: kick=%b left=%0d want 1 255", seen, coins_left); end
      wait_idle(20, idle);
   endtask

   task automatic test_reset_mid();
      int s;
      bit seen;
      do_reset();
      hop_auto = 1'b0;
      do_refill(5);
      do_request(3);
      wait_kick(seen);
      tick();
      reset = 1'b1;
      #1;
      checks++; if ({hopper_kick, paying, jam, empty_alarm, req_overflow} !== 5'b0 || coins_owed !== '0 || coins_left !== '0) begin
         failures++; $display("FAIL rstmid_outputs: flags=%b owed=%0d left=%0d want 00000 0 0",
                              {hopper_kick, paying, jam, empty_alarm, req_overflow}, coins_owed, coins_left);
      end
      tick();
      reset = 1'b0;
      s = kick_times.size();
      repeat (6) tick();
      checks++; if (kick_times.size() != s || paying !== 1'b0) begin
         failures++; $display("FAIL rstmid_release: kicks=%0d paying=%b want 0 0", kick_times.size() - s, paying);
      end
   endtask

   task automatic test_random();
      int model_left, d, k, cnt, sum, start, n, amt;
      int acc[$];
      int groups[$];
      bit idle, same;
      do_reset();
      model_left = 0;
      hop_auto = 1'b1;
      for (int r = 0; r < 8; r++) begin
         d = $urandom_range(0, 5);
         hop_delay = d;
         if (model_left < 45) begin do_refill(50); model_left += 50; end
         acc.delete();
         sum = 0;
         start = kick_times.size();
         k = $urandom_range(1, 3);
         for (int i = 0; i < k; i++) begin
            cnt = $urandom_range(0, 15);
            if (cnt != 0) begin acc.push_back(cnt); sum += cnt; end
            do_request(cnt);
         end
         checks++; if (coins_owed !== INV_W'(sum)) begin failures++; $display("FAIL rnd_owed_queued: round %0d owed=%0d want %0d", r, coins_owed, sum); end
         n = 0;
         while (paying === 1'b1 && n < 600) begin
            if ($urandom_range(0, 15) == 0) begin
               amt = $urandom_range(1, 3);
               do_refill(amt);
               model_left += amt;
            end else begin
               tick();
            end
            n++;
         end
         idle = (paying === 1'b0);
         model_left -= sum;
         checks++; if (!idle) begin failures++; $display("FAIL rnd_idle: round %0d paying still high, want 0", r); end
         checks++; if (coins_left !== INV_W'(model_left) || coins_owed !== '0) begin
            failures++; $display("FAIL rnd_counts: round %0d left=%0d owed=%0d want %0d 0", r, coins_left, coins_owed, model_left);
         end
         // Kicks within one request are evenly spaced; a longer gap starts the next request
         groups.delete();
         for (int i = start; i < kick_times.size(); i++) begin
            if (i == start || kick_times[i] - kick_times[i-1] != d + 2 + GAP_CYCLES) groups.push_back(1);
            else groups[groups.size()-1] = groups[groups.size()-1] + 1;
         end
         same = (groups.size() == acc.size());
         if (same) for (int i = 0; i < acc.size(); i++) if (groups[i] != acc[i]) same = 1'b0;
         checks++; if (!same) begin failures++; $display("FAIL rnd_order: round %0d kick groups %p want %p", r, groups, acc); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_jam();
      test_timeout_edge();
      test_empty();
      test_overflow();
      test_simultaneous();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
